// File: rtl/alu_req_arbiter.sv
// Round-robin front end that shares a single ALU8bit between NUM_REQ requesters.
// Holds one command in flight and returns the captured ALU outputs on a valid/ready channel.
module alu_req_arbiter #(
    parameter  int NUM_REQ = 2,
    parameter  int TAG_W   = 2,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [4*NUM_REQ-1:0]     req_op,
    input  logic [8*NUM_REQ-1:0]     req_a,
    input  logic [8*NUM_REQ-1:0]     req_b,
    input  logic [TAG_W*NUM_REQ-1:0] req_tag,
    output logic [3:0]               alu_op,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    input  logic [7:0]               alu_result,
    input  logic [15:0]              alu_product,
    input  logic                     alu_of,
    input  logic                     alu_zero,
    input  logic                     alu_slt,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [TAG_W-1:0]         resp_tag,
    output logic [7:0]               resp_result,
    output logic [15:0]              resp_product,
    output logic                     resp_of,
    output logic                     resp_zero,
    output logic                     resp_slt,
    output logic                     resp_illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP
    } state_t;

    localparam logic [3:0] OP_NOP = 4'b1111;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_id;
    logic [TAG_W-1:0]  r_tag;
    logic [3:0]        r_alu_op;
    logic [7:0]        r_alu_a;
    logic [7:0]        r_alu_b;

    logic              r_resp_valid;
    logic [7:0]        r_resp_result;
    logic [15:0]       r_resp_product;
    logic              r_resp_of;
    logic              r_resp_zero;
    logic              r_resp_slt;
    logic              r_resp_illegal;

    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_gnt_idx;
    logic               w_found;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [3:0]         w_op;
    logic [7:0]         w_a;
    logic [7:0]         w_b;
    logic [TAG_W-1:0]   w_tag;
    logic               w_accept;
    logic               w_resp_done;

    // Two passes: indices at/after the pointer first, then the wrapped ones.
    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[i] && (i >= int'(r_ptr))) begin
                w_found   = 1'b1;
                w_gnt[i]  = 1'b1;
                w_gnt_idx = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[i] && (i < int'(r_ptr))) begin
                w_found   = 1'b1;
                w_gnt[i]  = 1'b1;
                w_gnt_idx = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_op  = '0;
        w_a   = '0;
        w_b   = '0;
        w_tag = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_op  = req_op[i*4 +: 4];
                w_a   = req_a[i*8 +: 8];
                w_b   = req_b[i*8 +: 8];
                w_tag = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    always_comb begin
        if (w_gnt_idx == ID_W'(NUM_REQ - 1)) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = w_gnt_idx + ID_W'(1);
        end
    end

    assign w_accept    = (r_state == S_IDLE) && w_found;
    assign w_resp_done = (r_state == S_RESP) && resp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:    if (w_accept) w_state_nxt = S_ISSUE;
            S_ISSUE:   w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_RESP;
            S_RESP:    if (resp_ready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // ALU inputs stay held through CAPTURE because its flags are combinational.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= '0;
            r_id     <= '0;
            r_tag    <= '0;
            r_alu_op <= OP_NOP;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
        end else if (w_accept) begin
            r_ptr    <= w_ptr_nxt;
            r_id     <= w_gnt_idx;
            r_tag    <= w_tag;
            r_alu_op <= w_op;
            r_alu_a  <= w_a;
            r_alu_b  <= w_b;
        end else if (r_state == S_CAPTURE) begin
            r_alu_op <= OP_NOP;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid   <= 1'b0;
            r_resp_result  <= '0;
            r_resp_product <= '0;
            r_resp_of      <= 1'b0;
            r_resp_zero    <= 1'b0;
            r_resp_slt     <= 1'b0;
            r_resp_illegal <= 1'b0;
        end else if (r_state == S_CAPTURE) begin
            r_resp_valid   <= 1'b1;
            r_resp_result  <= alu_result;
            r_resp_product <= alu_product;
            r_resp_of      <= alu_of;
            r_resp_zero    <= alu_zero;
            r_resp_slt     <= alu_slt;
            r_resp_illegal <= (r_alu_op >= 4'b1100);
        end else if (w_resp_done) begin
            r_resp_valid   <= 1'b0;
        end
    end

    assign req_ready    = (r_state == S_IDLE) ? w_gnt : '0;
    assign alu_op       = r_alu_op;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign resp_valid   = r_resp_valid;
    assign resp_id      = r_id;
    assign resp_tag     = r_tag;
    assign resp_result  = r_resp_result;
    assign resp_product = r_resp_product;
    assign resp_of      = r_resp_of;
    assign resp_zero    = r_resp_zero;
    assign resp_slt     = r_resp_slt;
    assign resp_illegal = r_resp_illegal;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: behavioural ALU8bit model, scoreboard of
// accepted commands, directed steps for ordering, back-pressure and reset.
module tb_alu_req_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_tag;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_result;
    logic [15:0] alu_product;
    logic        alu_of;
    logic        alu_zero;
    logic        alu_slt;
    logic        resp_valid;
    logic        resp_ready;
    logic [0:0]  resp_id;
    logic [1:0]  resp_tag;
    logic [7:0]  resp_result;
    logic [15:0] resp_product;
    logic        resp_of;
    logic        resp_zero;
    logic        resp_slt;
    logic        resp_illegal;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    typedef struct packed {
        logic [7:0]  r;
        logic [15:0] p;
        logic        of;
        logic        slt;
    } calc_t;

    typedef struct {
        logic [0:0]  id;
        logic [1:0]  tag;
        logic [7:0]  r;
        logic [15:0] p;
        logic        of;
        logic        zero;
        logic        slt;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   gnt_log[$];
    int   gnt_cyc[$];

    alu_req_arbiter #(.NUM_REQ(2), .TAG_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_product(alu_product),
        .alu_of(alu_of), .alu_zero(alu_zero), .alu_slt(alu_slt),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_tag(resp_tag),
        .resp_result(resp_result), .resp_product(resp_product),
        .resp_of(resp_of), .resp_zero(resp_zero), .resp_slt(resp_slt),
        .resp_illegal(resp_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic calc_t calc(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        calc_t c;
        c = '0;
        case (op)
            4'h9: begin
                c.r  = a + b;
                c.of = (a[7] == b[7]) && (c.r[7] != a[7]);
            end
            4'hA: begin
                c.r   = a - b;
                c.of  = (a[7] != b[7]) && (c.r[7] != a[7]);
                c.slt = ($signed(a) < $signed(b));
            end
            4'hB: c.p = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
            default: ;
        endcase
        return c;
    endfunction

    // ALU8bit stand-in: result/product registered, flags combinational
    always @(posedge clk) begin
        alu_result  <= calc(alu_op, alu_a, alu_b).r;
        alu_product <= calc(alu_op, alu_a, alu_b).p;
    end
    assign alu_of   = calc(alu_op, alu_a, alu_b).of;
    assign alu_slt  = calc(alu_op, alu_a, alu_b).slt;
    assign alu_zero = (alu_result == 8'h00);

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic set_req(input bit [0:0] idx, input logic [3:0] op,
                           input logic [7:0] a, input logic [7:0] b, input logic [1:0] tag);
        req_op[int'(idx)*4 +: 4]  = op;
        req_a[int'(idx)*8 +: 8]   = a;
        req_b[int'(idx)*8 +: 8]   = b;
        req_tag[int'(idx)*2 +: 2] = tag;
    endtask

    task automatic do_cmd(input bit [0:0] idx, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [1:0] tag, output int lat);
        bit hit;
        lat = -1;
        set_req(idx, op, a, b, tag);
        req_valid[idx] = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            hit = req_valid[idx] && req_ready[idx];
        end
        chk("accept_seen", 32'(hit), 32'd1);
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        if (hit) begin
            hit = 1'b0;
            lat = 0;
            for (int k = 0; k < 10 && !hit; k++) begin
                @(negedge clk);
                lat++;
                hit = resp_valid;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    always @(posedge rst) sb.delete();

    // Scoreboard: push at accept, pop and compare at response handshake
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_t  e;
                    calc_t c;
                    c      = calc(req_op[i*4 +: 4], req_a[i*8 +: 8], req_b[i*8 +: 8]);
                    e.id   = 1'(i);
                    e.tag  = req_tag[i*2 +: 2];
                    e.r    = c.r;
                    e.p    = c.p;
                    e.of   = c.of;
                    e.slt  = c.slt;
                    e.zero = (c.r == 8'h00);
                    e.ill  = (req_op[i*4 +: 4] >= 4'hC);
                    sb.push_back(e);
                    gnt_log.push_back(i);
                    gnt_cyc.push_back(cyc);
                end
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    chk("resp_unexpected", 32'(resp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_id", 32'(resp_id), 32'(e.id));
                    chk("sb_tag", 32'(resp_tag), 32'(e.tag));
                    chk("sb_result", 32'(resp_result), 32'(e.r));
                    chk("sb_product", 32'(resp_product), 32'(e.p));
                    chk("sb_of", 32'(resp_of), 32'(e.of));
                    chk("sb_zero", 32'(resp_zero), 32'(e.zero));
                    chk("sb_slt", 32'(resp_slt), 32'(e.slt));
                    chk("sb_illegal", 32'(resp_illegal), 32'(e.ill));
                end
            end
        end
    end

    initial begin
        int  lat;
        bit  done;
        rst        = 1'b1;
        resp_ready = 1'b1;
        req_valid  = '0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        req_tag    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'hF);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_resp_result", 32'(resp_result), 32'd0);
        chk("rst_resp_product", 32'(resp_product), 32'd0);
        rst = 1'b0;
        tick();

        do_cmd(1'b0, 4'h9, 8'h05, 8'h03, 2'd1, lat);
        chk("add_latency", 32'(lat), 32'd3);
        chk("add_result", 32'(resp_result), 32'h08);
        chk("add_id", 32'(resp_id), 32'd0);
        chk("add_tag", 32'(resp_tag), 32'd1);
        chk("add_of", 32'(resp_of), 32'd0);
        tick();
        chk("add_valid_drop", 32'(resp_valid), 32'd0);

        do_cmd(1'b1, 4'hA, 8'h03, 8'h05, 2'd2, lat);
        chk("sub_result", 32'(resp_result), 32'hFE);
        chk("sub_slt", 32'(resp_slt), 32'd1);
        chk("sub_zero", 32'(resp_zero), 32'd0);
        chk("sub_id", 32'(resp_id), 32'd1);
        tick();

        do_cmd(1'b0, 4'hB, 8'hFD, 8'h04, 2'd3, lat);
        chk("mul_product", 32'(resp_product), 32'hFFF4);
        chk("mul_result", 32'(resp_result), 32'h00);
        tick();
        do_cmd(1'b0, 4'hC, 8'h12, 8'h34, 2'd0, lat);
        chk("ill_flag", 32'(resp_illegal), 32'd1);
        chk("ill_result", 32'(resp_result), 32'h00);
        chk("ill_product", 32'(resp_product), 32'h0000);
        tick();

        // both requesters held from reset: strict alternation, 4 cycles apart
        rst = 1'b1; #2; rst = 1'b0;
        gnt_log.delete();
        gnt_cyc.delete();
        set_req(1'b0, 4'h9, 8'h7F, 8'h01, 2'd2);
        set_req(1'b1, 4'hA, 8'h80, 8'h01, 2'd3);
        req_valid = 2'b11;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            done = (gnt_log.size() >= 4);
        end
        chk("rr_grants_seen", 32'(done), 32'd1);
        tick();
        req_valid = 2'b00;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            done = (sb.size() == 0) && !resp_valid;
        end
        chk("rr_drain", 32'(done), 32'd1);
        if (gnt_log.size() >= 4) begin
            chk("rr_g0", 32'(gnt_log[0]), 32'd0);
            chk("rr_g1", 32'(gnt_log[1]), 32'd1);
            chk("rr_g2", 32'(gnt_log[2]), 32'd0);
            chk("rr_g3", 32'(gnt_log[3]), 32'd1);
            chk("rr_gap01", 32'(gnt_cyc[1] - gnt_cyc[0]), 32'd4);
            chk("rr_gap23", 32'(gnt_cyc[3] - gnt_cyc[2]), 32'd4);
        end
        tick();

        // response back-pressure with another requester waiting
        resp_ready = 1'b0;
        do_cmd(1'b0, 4'h9, 8'hFF, 8'h01, 2'd1, lat);
        set_req(1'b1, 4'h9, 8'h01, 8'h01, 2'd0);
        req_valid[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_result", 32'(resp_result), 32'h00);
            chk("hold_zero", 32'(resp_zero), 32'd1);
            chk("hold_tag", 32'(resp_tag), 32'd1);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_alu_op", 32'(alu_op), 32'hF);
            chk("hold_alu_a", 32'(alu_a), 32'd0);
        end
        tick();
        req_valid[1] = 1'b0;
        resp_ready   = 1'b1;
        tick();
        tick();

        // async reset while in ISSUE
        set_req(1'b0, 4'h9, 8'h11, 8'h22, 2'd2);
        req_valid[0] = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            done = req_ready[0];
        end
        chk("issue_accept", 32'(done), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("issue_rst_valid", 32'(resp_valid), 32'd0);
        chk("issue_rst_alu_op", 32'(alu_op), 32'hF);
        chk("issue_rst_alu_a", 32'(alu_a), 32'd0);
        chk("issue_rst_req_ready", 32'(req_ready), 32'd0);
        #1 rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("issue_no_stale", 32'(resp_valid), 32'd0);
        end
        tick();

        // async reset while in RESP; pointer returns to 0
        resp_ready = 1'b0;
        do_cmd(1'b0, 4'hA, 8'h09, 8'h02, 2'd3, lat);
        chk("resp_pre_valid", 32'(resp_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("resp_rst_valid", 32'(resp_valid), 32'd0);
        chk("resp_rst_result", 32'(resp_result), 32'd0);
        chk("resp_rst_id", 32'(resp_id), 32'd0);
        chk("resp_rst_tag", 32'(resp_tag), 32'd0);
        chk("resp_rst_alu_op", 32'(alu_op), 32'hF);
        #1 rst = 1'b0;
        resp_ready = 1'b1;
        tick();
        gnt_log.delete();
        gnt_cyc.delete();
        set_req(1'b0, 4'h9, 8'h01, 8'h02, 2'd0);
        set_req(1'b1, 4'h9, 8'h03, 8'h04, 2'd1);
        req_valid = 2'b11;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            done = (gnt_log.size() >= 1);
        end
        chk("ptr_rst_seen", 32'(done), 32'd1);
        if (done) chk("ptr_rst_grant", 32'(gnt_log[0]), 32'd0);
        tick();
        req_valid = 2'b00;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            done = (sb.size() == 0) && !resp_valid;
        end
        chk("final_drain", 32'(done), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
